// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - screen geometry, bus widths and feeder state shared with the VGA output block
package vga_pkg;

  localparam int SCREEN_WIDTH  = 1024;
  localparam int SCREEN_HEIGHT = 768;
  localparam int X_W           = 11;
  localparam int Y_W           = 12;
  localparam int D_W           = 12;

  typedef enum logic {
    FILL = 1'b0,
    WAIT = 1'b1
  } feed_state_t;

endpackage

// File: rtl/vga_line_feeder_if.sv
// rtl/vga_line_feeder_if.sv - upstream pixel stream plus VGA line-buffer write port
interface vga_line_feeder_if;
  import vga_pkg::*;

  logic [D_W-1:0] PIX_DATA;
  logic           PIX_VALID;
  logic           PIX_READY;
  logic [Y_W-1:0] REQ_Y;
  logic           PROGRAM_OUT;
  logic [X_W-1:0] X_OUT;
  logic [Y_W-1:0] Y_OUT;
  logic [D_W-1:0] DATA_OUT;

  // master is the feeder: it sinks pixels and drives the write port
  modport master (
    input  PIX_DATA, PIX_VALID,
    output PIX_READY, REQ_Y, PROGRAM_OUT, X_OUT, Y_OUT, DATA_OUT
  );

  modport slave (
    output PIX_DATA, PIX_VALID,
    input  PIX_READY, REQ_Y, PROGRAM_OUT, X_OUT, Y_OUT, DATA_OUT
  );

endinterface

// File: rtl/edge_detect_rise.sv
// rtl/edge_detect_rise.sv - one-bit registered rising-edge detector, synchronous active-high reset
module edge_detect_rise (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_rise
);

  logic r_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_q <= 1'b0;
    else       r_q <= i_d;
  end

  assign o_rise = i_d & ~r_q;

endmodule

// File: rtl/vga_line_feeder.sv
// rtl/vga_line_feeder.sv - fills the VGA single-line buffer one line ahead of the raster
module vga_line_feeder
  import vga_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              LINEEND_IN,
  vga_line_feeder_if.master bus,
  output logic              LINE_DONE,
  output logic              UNDERRUN
);

  feed_state_t    r_state, w_state_nxt;
  logic           w_lineend_rise, w_accept, w_last, w_underrun, w_ready_nxt;
  logic [X_W-1:0] r_x_cnt, w_x_cnt_nxt;
  logic [Y_W-1:0] r_req_y, w_req_y_nxt;
  logic           r_pix_ready, r_prog_n, r_line_done, r_underrun;
  logic [X_W-1:0] r_x_out;
  logic [Y_W-1:0] r_y_out;
  logic [D_W-1:0] r_data_out;

  edge_detect_rise u_lineend_edge (
    .i_clk  (CLK),
    .i_rst  (RST),
    .i_d    (LINEEND_IN),
    .o_rise (w_lineend_rise)
  );

  assign w_accept = bus.PIX_VALID & r_pix_ready;
  assign w_last   = w_accept && (r_x_cnt == X_W'(SCREEN_WIDTH - 1));

  always_ff @(posedge CLK) begin
    if (RST) r_state <= FILL;
    else     r_state <= w_state_nxt;
  end

  // a line-end edge coinciding with the final beat skips WAIT entirely
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FILL: if (w_last && !w_lineend_rise) w_state_nxt = WAIT;
      WAIT: if (w_lineend_rise)            w_state_nxt = FILL;
    endcase
  end

  always_comb begin
    w_ready_nxt = (w_state_nxt == FILL);
    w_underrun  = (r_state == FILL) && w_lineend_rise && !w_last;
    w_x_cnt_nxt = r_x_cnt;
    w_req_y_nxt = r_req_y;
    if (w_lineend_rise) begin
      w_x_cnt_nxt = '0;
      w_req_y_nxt = (r_req_y == Y_W'(SCREEN_HEIGHT - 1)) ? '0 : r_req_y + Y_W'(1);
    end else if (w_accept) begin
      w_x_cnt_nxt = w_last ? '0 : r_x_cnt + X_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_x_cnt     <= '0;
      r_req_y     <= '0;
      r_pix_ready <= 1'b0;
      r_prog_n    <= 1'b1;
      r_x_out     <= '0;
      r_y_out     <= '0;
      r_data_out  <= '0;
      r_line_done <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_x_cnt     <= w_x_cnt_nxt;
      r_req_y     <= w_req_y_nxt;
      r_pix_ready <= w_ready_nxt;
      r_prog_n    <= ~w_accept;
      r_line_done <= w_last;
      r_underrun  <= w_underrun;
      if (w_accept) begin
        r_x_out    <= r_x_cnt;
        r_y_out    <= r_req_y;
        r_data_out <= bus.PIX_DATA;
      end
    end
  end

  assign bus.PIX_READY   = r_pix_ready;
  assign bus.REQ_Y       = r_req_y;
  assign bus.PROGRAM_OUT = r_prog_n;
  assign bus.X_OUT       = r_x_out;
  assign bus.Y_OUT       = r_y_out;
  assign bus.DATA_OUT    = r_data_out;
  assign LINE_DONE       = r_line_done;
  assign UNDERRUN        = r_underrun;

endmodule

// File: tb/tb_vga_line_feeder.sv
// tb/tb_vga_line_feeder.sv - directed and randomized checks of vga_line_feeder against a line-level model
module tb_vga_line_feeder;
  import vga_pkg::*;

  logic CLK = 1'b0;
  logic RST;
  logic LE;
  logic line_done, underrun;

  vga_line_feeder_if bus ();

  vga_line_feeder dut (
    .CLK        (CLK),
    .RST        (RST),
    .LINEEND_IN (LE),
    .bus        (bus.master),
    .LINE_DONE  (line_done),
    .UNDERRUN   (underrun)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;
  int n_wr, n_done, n_under;

  // model: which line is being requested, how many pixels of it are in, whether we are filling
  bit m_ready, m_fill, m_lq;
  int m_x, m_y;
  int e_prog, e_xo, e_yo, e_do, e_done, e_under;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit rst, input bit valid, input bit le, input int data);
    bit rise, acc, last;
    if (rst) begin
      m_ready = 0; m_fill = 1; m_lq = 0; m_x = 0; m_y = 0;
      e_prog = 1; e_xo = 0; e_yo = 0; e_do = 0; e_done = 0; e_under = 0;
    end else begin
      rise = le && !m_lq;
      m_lq = le;
      acc  = valid && m_ready;
      last = acc && (m_x == SCREEN_WIDTH - 1);
      e_prog = acc ? 0 : 1;
      if (acc) begin
        e_xo = m_x; e_yo = m_y; e_do = data;
      end
      e_done  = last ? 1 : 0;
      e_under = (m_fill && rise && !last) ? 1 : 0;
      if (rise) begin
        m_y = (m_y + 1) % SCREEN_HEIGHT;
        m_x = 0;
        m_fill = 1;
      end else if (acc) begin
        if (last) begin
          m_x = 0;
          m_fill = 0;
        end else begin
          m_x = m_x + 1;
        end
      end
      m_ready = m_fill;
    end
  endtask

  task automatic cycle(input bit rst, input bit valid, input bit le, input logic [11:0] data);
    RST = rst; LE = le; bus.PIX_VALID = valid; bus.PIX_DATA = data;
    model_step(rst, valid, le, int'(data));
    @(posedge CLK);
    #1;
    chk("ready",     32'(bus.PIX_READY),   32'(m_ready));
    chk("req_y",     32'(bus.REQ_Y),       32'(m_y));
    chk("prog",      32'(bus.PROGRAM_OUT), 32'(e_prog));
    chk("x_out",     32'(bus.X_OUT),       32'(e_xo));
    chk("y_out",     32'(bus.Y_OUT),       32'(e_yo));
    chk("data_out",  32'(bus.DATA_OUT),    32'(e_do));
    chk("line_done", 32'(line_done),       32'(e_done));
    chk("underrun",  32'(underrun),        32'(e_under));
    if (bus.PROGRAM_OUT === 1'b0) n_wr++;
    if (line_done === 1'b1) n_done++;
    if (underrun === 1'b1) n_under++;
  endtask

  task automatic clr();
    n_wr = 0; n_done = 0; n_under = 0;
  endtask

  function automatic logic [11:0] rnd12();
    return 12'($urandom);
  endfunction

  initial begin
    int guard, first_wr;
    RST = 1; LE = 0; bus.PIX_VALID = 0; bus.PIX_DATA = '0;
    model_step(1, 0, 0, 0);
    clr();

    // reset then line 0 with constant red pixels
    repeat (3) cycle(1, 1, 0, 12'hF00);
    chk("rst_ready", 32'(bus.PIX_READY), 32'd0);
    chk("rst_prog",  32'(bus.PROGRAM_OUT), 32'd1);
    clr();
    guard = 0; first_wr = -1;
    while (n_done == 0 && guard < 1200) begin
      cycle(0, 1, 0, 12'hF00);
      guard++;
      if (first_wr < 0 && n_wr == 1) first_wr = guard;
    end
    chk("first_write_cycle", 32'(first_wr), 32'd2);
    chk("fill0_done",   32'(n_done), 32'd1);
    chk("fill0_writes", 32'(n_wr), 32'd1024);
    chk("fill0_last_x", 32'(bus.X_OUT), 32'd1023);
    repeat (10) cycle(0, 1, 0, rnd12());
    chk("wait_ready", 32'(bus.PIX_READY), 32'd0);

    // line-end level held 40 cycles counts once
    clr();
    repeat (40) cycle(0, 0, 1, rnd12());
    chk("pace_req_y", 32'(bus.REQ_Y), 32'd1);
    chk("pace_under", 32'(n_under), 32'd0);
    chk("pace_ready", 32'(bus.PIX_READY), 32'd1);

    // backpressure: every third cycle has no valid
    cycle(0, 0, 0, rnd12());
    clr();
    guard = 0;
    while (n_done == 0 && guard < 2000) begin
      cycle(0, (guard % 3) != 2, 0, rnd12());
      guard++;
    end
    chk("bp_writes", 32'(n_wr), 32'd1024);
    chk("bp_done",   32'(n_done), 32'd1);

    // underrun after 500 beats
    cycle(0, 0, 1, rnd12());
    cycle(0, 0, 0, rnd12());
    chk("ur_start_y", 32'(bus.REQ_Y), 32'd2);
    clr();
    guard = 0;
    while (n_wr < 500 && guard < 700) begin
      cycle(0, 1, 0, rnd12());
      guard++;
    end
    repeat (5) cycle(0, 0, 0, rnd12());
    cycle(0, 0, 1, rnd12());
    chk("ur_pulse", 32'(underrun), 32'd1);
    chk("ur_req_y", 32'(bus.REQ_Y), 32'd3);
    cycle(0, 1, 0, rnd12());
    chk("ur_pulse_len", 32'(underrun), 32'd0);
    chk("ur_next_x", 32'(bus.X_OUT), 32'd0);
    chk("ur_next_prog", 32'(bus.PROGRAM_OUT), 32'd0);
    chk("ur_no_done", 32'(n_done), 32'd0);
    chk("ur_count", 32'(n_under), 32'd1);

    // sweep lines by rapid line-end edges up to the last line
    guard = 0;
    while (m_y != SCREEN_HEIGHT - 1 && guard < 4000) begin
      cycle(0, $urandom_range(0, 1) == 1, 1, rnd12());
      cycle(0, $urandom_range(0, 1) == 1, 0, rnd12());
      guard++;
    end
    cycle(0, 0, 0, rnd12());
    chk("at_last_line", 32'(bus.REQ_Y), 32'd767);

    // final beat coinciding with a line-end edge on line 767
    guard = 0;
    while (!(m_x == SCREEN_WIDTH - 1 && m_ready) && guard < 1200) begin
      cycle(0, 1, 0, rnd12());
      guard++;
    end
    chk("wrap_reached", 32'(m_x == SCREEN_WIDTH - 1), 32'd1);
    cycle(0, 1, 1, rnd12());
    chk("wrap_done",  32'(line_done), 32'd1);
    chk("wrap_under", 32'(underrun), 32'd0);
    chk("wrap_req_y", 32'(bus.REQ_Y), 32'd0);
    chk("wrap_ready", 32'(bus.PIX_READY), 32'd1);
    cycle(0, 1, 1, rnd12());
    chk("wrap_next_x", 32'(bus.X_OUT), 32'd0);
    chk("wrap_next_y", 32'(bus.Y_OUT), 32'd0);

    // reset at beat 300
    cycle(0, 0, 0, rnd12());
    cycle(0, 0, 1, rnd12());
    guard = 0;
    while (m_x != 300 && guard < 600) begin
      cycle(0, 1, 0, rnd12());
      guard++;
    end
    cycle(1, 1, 0, rnd12());
    chk("mrst_ready", 32'(bus.PIX_READY), 32'd0);
    chk("mrst_prog",  32'(bus.PROGRAM_OUT), 32'd1);
    chk("mrst_x",     32'(bus.X_OUT), 32'd0);
    chk("mrst_y",     32'(bus.Y_OUT), 32'd0);
    chk("mrst_data",  32'(bus.DATA_OUT), 32'd0);
    chk("mrst_req_y", 32'(bus.REQ_Y), 32'd0);
    chk("mrst_done",  32'(line_done), 32'd0);
    chk("mrst_under", 32'(underrun), 32'd0);
    cycle(0, 1, 0, rnd12());
    cycle(0, 1, 0, rnd12());
    chk("mrst_restart_prog", 32'(bus.PROGRAM_OUT), 32'd0);
    chk("mrst_restart_x",    32'(bus.X_OUT), 32'd0);
    chk("mrst_restart_y",    32'(bus.Y_OUT), 32'd0);

    // randomized traffic with sporadic line ends and resets
    for (int i = 0; i < 4000; i++) begin
      cycle($urandom_range(0, 599) == 0,
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 299) < 150 ? m_lq : ($urandom_range(0, 29) == 0),
            rnd12());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vga_line_feeder.md
Name: vga_line_feeder

Overview:
Producer-side companion to the VGA output block. It fills that block's single-line pixel buffer one line ahead of the raster. It pulls 12-bit RGB444 pixels from an upstream renderer over a valid/ready stream and drives the VGA output's program/x/y/data write port. It also uses the VGA output's line-end blanking signal to pace line preparation.

Parameters:
SCREEN_WIDTH, 1024, pixels per line written per fill
SCREEN_HEIGHT, 768, lines per frame; line index wraps at this value
X_W, 11, width of X_OUT
Y_W, 12, width of Y_OUT / REQ_Y
D_W, 12, pixel width (RGB444)

Ports:
CLK  in  1  base clock (100 MHz domain)
RST  in  1  reset; synchronous, active-high
LINEEND_IN  in  1  VGA output line-end blanking level; the rising edge marks start of a new fill window
PIX_DATA  in  D_W  upstream pixel for the current (REQ_Y, next x)
PIX_VALID  in  1  upstream data valid
PIX_READY  out  1  feeder accepts PIX_DATA this cycle
REQ_Y  out  Y_W  line being requested upstream; stable throughout a fill
PROGRAM_OUT  out  1  write strobe to VGA output; active-LOW (0 = write this cycle)
X_OUT  out  X_W  write address (pixel x)
Y_OUT  out  Y_W  line index of the write (equals REQ_Y)
DATA_OUT  out  D_W  pixel written
LINE_DONE  out  1  one-cycle pulse when pixel SCREEN_WIDTH-1 is written
UNDERRUN  out  1  one-cycle pulse when a line-end edge arrives before the fill completes

Behaviour:
- Reset values:
  - PIX_READY=0, PROGRAM_OUT=1, X_OUT=0, Y_OUT=0, DATA_OUT=0, REQ_Y=0, LINE_DONE=0, UNDERRUN=0.
  - Internal x_cnt=0, line-end edge register=0.
  - State is FILL, so line 0 is primed immediately after reset.
- Edge detect:
  - lineend_rise = LINEEND_IN & ~lineend_q, with lineend_q registered each cycle.
  - A level held for N cycles counts as one edge.
- FSM states: FILL, WAIT.
- FILL:
  - PIX_READY=1 (registered, so it reflects state).
  - A beat is accepted when PIX_VALID & PIX_READY.
  - On an accepted beat in cycle t:
    - X_OUT <= x_cnt, DATA_OUT <= PIX_DATA, Y_OUT <= REQ_Y, PROGRAM_OUT <= 0 for cycle t+1 only.
    - x_cnt increments.
  - Gaps in PIX_VALID insert idle cycles: PROGRAM_OUT=1, X_OUT/DATA_OUT hold their last values.
  - On acceptance with x_cnt==SCREEN_WIDTH-1:
    - LINE_DONE pulses at t+1, x_cnt <= 0.
    - Go to WAIT; PIX_READY=0 from t+1.
- WAIT:
  - PIX_READY=0, PROGRAM_OUT=1.
  - On lineend_rise: REQ_Y <= (REQ_Y==SCREEN_HEIGHT-1) ? 0 : REQ_Y+1, x_cnt <= 0, go to FILL.
- Line-end edge during FILL before the final beat (underrun):
  - UNDERRUN pulses next cycle.
  - The partial line is abandoned; any beat accepted that same cycle is still written.
  - x_cnt <= 0, REQ_Y advances with wrap, stay in FILL.
- Final beat accepted in the same cycle as lineend_rise:
  - No underrun; LINE_DONE pulses.
  - REQ_Y advances and the block goes straight to FILL, skipping WAIT.
- Throughput and latency:
  - Up to 1 pixel/cycle; a line needs ≥1024 cycles.
  - Write latency is exactly 1 cycle from acceptance to the PROGRAM_OUT low cycle.
- Reset mid-operation:
  - All state returns to reset values next cycle.
  - The in-flight line is discarded and no LINE_DONE/UNDERRUN is emitted.
- Widths:
  - x_cnt is X_W bits and never exceeds SCREEN_WIDTH-1.
  - REQ_Y compare uses Y_W bits with no overflow past SCREEN_HEIGHT-1.

Decomposition:
- Shared package (vga_pkg): SCREEN_WIDTH, SCREEN_HEIGHT, X_W, Y_W, D_W, and the state enum {FILL, WAIT}, also to be used by the VGA output block.
- One sub-module, edge_detect_rise: a 1-bit registered rising-edge detector with synchronous reset, reusable for VSYNC.

Test Plan:
- Reset: hold RST 3 cycles, release with PIX_VALID=1, PIX_DATA=12'hF00 → first write (PROGRAM_OUT=0, X_OUT=0, Y_OUT=0, DATA_OUT=F00) occurs 1 cycle after the first PIX_READY=1 acceptance; after 1024 beats, LINE_DONE pulses once with X_OUT=1023 and the block enters WAIT.
- Backpressure: drop PIX_VALID every 3rd cycle → exactly 1024 writes with x 0..1023 contiguous; PROGRAM_OUT=1 on gap cycles; X_OUT/DATA_OUT unchanged during gaps.
- Line-end pacing: in WAIT, raise LINEEND_IN for 40 cycles → exactly one REQ_Y increment (0→1) and one new fill; no UNDERRUN.
- Underrun: hold PIX_VALID=0 after 500 beats, then pulse LINEEND_IN → UNDERRUN 1-cycle pulse, REQ_Y advances, next write has X_OUT=0; no LINE_DONE.
- Wrap and coincidence: with REQ_Y=767, make lineend_rise coincide with the 1024th beat → LINE_DONE=1, UNDERRUN=0, REQ_Y=0, PIX_READY stays 1 with no WAIT cycle.
- Reset mid-fill: assert RST at beat 300 → next cycle all outputs are at reset values; after release, fill restarts at X_OUT=0, Y_OUT=0.
